// File: rtl/if_fetch_queue.sv
// Pipelined instruction-fetch front end: issues in-order memory requests under a credit limit.
// Returned instructions are buffered with their PC in a FIFO; redirects flush it and drop stale responses.
module if_fetch_queue #(
   parameter int unsigned     XLEN            = 64,
   parameter int unsigned     INST_W          = 32,
   parameter int unsigned     FQ_DEPTH        = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = 64'h8000_0000
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       redirect_valid,
   input  logic [XLEN-1:0]                            redirect_pc,
   output logic                                       req_valid,
   input  logic                                       req_ready,
   output logic [XLEN-1:0]                            req_addr,
   input  logic                                       resp_valid,
   input  logic [INST_W-1:0]                          resp_data,
   output logic                                       inst_valid,
   input  logic                                       inst_ready,
   output logic [INST_W-1:0]                          inst,
   output logic [XLEN-1:0]                            inst_pc,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding
);

   localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
   localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

   localparam logic [OUT_W-1:0] MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
   localparam logic [SUM_W-1:0] DEPTH_S   = SUM_W'(FQ_DEPTH);
   localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);

   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [OUT_W-1:0]  outstanding_q, outstanding_d;
   logic [OUT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [INST_W-1:0] inst_mem_q [FQ_DEPTH];
   logic [XLEN-1:0]   pc_mem_q [FQ_DEPTH];

   logic [SUM_W-1:0]  inflight;
   logic [XLEN-1:0]   redir_pc;
   logic              req_fire, resp_fire, push, pop;
   logic              unused_redir_lsb;

   assign unused_redir_lsb = ^redirect_pc[1:0];
   assign redir_pc         = {redirect_pc[XLEN-1:2], 2'b00};
   assign inflight         = SUM_W'(count_q) + SUM_W'(outstanding_q);

   // Credit check reserves a queue slot for every in-flight request, so a push never overflows.
   assign req_valid = !rst && !redirect_valid && (outstanding_q < MAX_OUT)
                      && (inflight < DEPTH_S) && (drop_cnt_q == '0);
   assign req_fire  = req_valid && req_ready;
   assign resp_fire = resp_valid && (outstanding_q != '0);
   assign push      = resp_fire && (drop_cnt_q == '0) && !redirect_valid;
   assign pop       = (count_q != '0) && inst_ready && !redirect_valid;

   assign req_addr    = fetch_pc_q;
   assign outstanding = outstanding_q;
   assign inst_valid  = !rst && (count_q != '0);
   assign inst        = rst ? '0 : inst_mem_q[rd_ptr_q];
   assign inst_pc     = rst ? '0 : pc_mem_q[rd_ptr_q];

   always_comb begin
      fetch_pc_d    = req_fire ? fetch_pc_q + PC_STEP : fetch_pc_q;
      resp_pc_d     = push ? resp_pc_q + PC_STEP : resp_pc_q;
      wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
      outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(resp_fire);
      drop_cnt_d    = (resp_fire && (drop_cnt_q != '0)) ? drop_cnt_q - OUT_W'(1) : drop_cnt_q;
      if (redirect_valid) begin
         fetch_pc_d = redir_pc;
         resp_pc_d  = redir_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         // Everything still in flight after this cycle belongs to the old path.
         drop_cnt_d = outstanding_q - OUT_W'(resp_fire);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         for (int i = 0; i < int'(FQ_DEPTH); i++) begin
            inst_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         if (push) begin
            inst_mem_q[wr_ptr_q] <= resp_data;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
         end
      end
   end

   a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
      !(resp_valid && (outstanding_q == '0)))
      else $error("if_fetch_queue: response with no request outstanding");

endmodule
